// File: rtl/led_drv_pkg.sv
// Shared opcode constants and state type for the LED pattern driver.
package led_drv_pkg;

   localparam logic [1:0] OP_LOAD   = 2'd0;
   localparam logic [1:0] OP_ROTATE = 2'd1;
   localparam logic [1:0] OP_BLINK  = 2'd2;
   localparam logic [1:0] OP_BRIGHT = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STATIC = 2'd1,
      ROTATE = 2'd2,
      BLINK  = 2'd3
   } led_state_t;

   // Rotate an 8-bit pattern left by one position, MSB wrapping to LSB.
   function automatic logic [7:0] rotl8(input logic [7:0] p);
      return {p[6:0], p[7]};
   endfunction

endpackage

// File: rtl/led_pwm.sv
// Global brightness PWM: free-running counter compared against a duty value.
// Duty 0 is always off, duty all-ones is always on.
module led_pwm #(
   parameter int PWM_BITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PWM_BITS-1:0] duty,
   output logic                pwm_on
);

   logic [PWM_BITS-1:0] cnt_q;

   // Free-running PWM counter; never cleared by commands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + PWM_BITS'(1);
      end
   end

   // Duty compare; all-ones forces the output fully on.
   always_comb begin
      pwm_on = (cnt_q < duty) || (duty == {PWM_BITS{1'b1}});
   end

endmodule

// File: rtl/led_pattern_driver.sv
// Drives the 8 board LEDs from commands: static pattern, timed rotation and
// timed blinking, all gated by a global PWM brightness.
//
// Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is registered and drops for exactly the one cycle after each
// accept, so a held cmd_valid is taken at most every second cycle. The
// producer must hold cmd_op/cmd_data stable while cmd_valid is high.
module led_pattern_driver
   import led_drv_pkg::*;
#(
   parameter int TICK_DIV = 1_000_000,
   parameter int PWM_BITS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [7:0]   cmd_data,
   output logic [7:0]   leds,
   output led_state_t   dbg_state
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   led_state_t          state_q, state_d;
   logic [7:0]          pattern_q, pattern_d;
   logic                phase_q, phase_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [TW-1:0]       tick_q, tick_d;
   logic [7:0]          shown;
   logic [7:0]          leds_d;
   logic                accept;
   logic                step;
   logic                pwm_on;

   assign accept    = cmd_valid && cmd_ready;
   assign step      = (tick_q == TICK_LAST);
   assign dbg_state = state_q;

   led_pwm #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .clk    (clk),
      .rst_n  (rst_n),
      .duty   (duty_q),
      .pwm_on (pwm_on)
   );

   // Next-state logic: a pattern command beats a same-cycle step pulse.
   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      phase_d   = phase_q;
      duty_d    = duty_q;
      tick_d    = step ? '0 : tick_q + TW'(1);
      if (accept) begin
         case (cmd_op)
            OP_LOAD: begin
               state_d   = STATIC;
               pattern_d = cmd_data;
               phase_d   = 1'b1;
               tick_d    = '0;
            end
            OP_ROTATE: begin
               state_d   = ROTATE;
               pattern_d = cmd_data;
               phase_d   = 1'b1;
               tick_d    = '0;
            end
            OP_BLINK: begin
               state_d   = BLINK;
               pattern_d = cmd_data;
               phase_d   = 1'b1;
               tick_d    = '0;
            end
            default: begin
               duty_d = cmd_data[PWM_BITS-1:0];
            end
         endcase
      end else if (step) begin
         if (state_q == ROTATE) begin
            pattern_d = rotl8(pattern_q);
         end
         if (state_q == BLINK) begin
            phase_d = ~phase_q;
         end
      end
   end

   // Displayed pattern before brightness gating.
   always_comb begin
      shown = pattern_q;
      case (state_q)
         IDLE:    shown = 8'h00;
         BLINK:   shown = phase_q ? pattern_q : 8'h00;
         default: shown = pattern_q;
      endcase
      leds_d = shown & {8{pwm_on}};
   end

   // State, pattern, brightness, tick counter and handshake registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pattern_q <= 8'h00;
         phase_q   <= 1'b1;
         duty_q    <= {PWM_BITS{1'b1}};
         tick_q    <= '0;
         cmd_ready <= 1'b1;
         leds      <= 8'h00;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         phase_q   <= phase_d;
         duty_q    <= duty_d;
         tick_q    <= tick_d;
         cmd_ready <= !accept;
         leds      <= leds_d;
      end
   end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Self-checking bench for led_pattern_driver with TICK_DIV=4, PWM_BITS=4.
module tb_led_pattern_driver;
   import led_drv_pkg::*;

   localparam int TD = 4;
   localparam int PB = 4;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'd0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready;
   logic [7:0] leds;
   led_state_t dbg_state;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   led_pattern_driver #(
      .TICK_DIV (TD),
      .PWM_BITS (PB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .leds      (leds),
      .dbg_state (dbg_state)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Everything derives from the pattern given at the last pattern command and
   // the number of edges since then: steps = age / TD.
   led_state_t m_mode;
   logic [7:0] m_pat0;
   int         m_age;
   int         m_edges;
   int         m_duty;
   logic       m_ready;
   logic [7:0] exp_q[$];

   function automatic logic [7:0] rot_by(input logic [7:0] p, input int n);
      logic [15:0] w;
      w = {p, p} << (n % 8);
      return w[15:8];
   endfunction

   function automatic logic [7:0] model_leds();
      int steps;
      logic [7:0] shown;
      bit on;
      steps = m_age / TD;
      case (m_mode)
         IDLE:    shown = 8'h00;
         STATIC:  shown = m_pat0;
         ROTATE:  shown = rot_by(m_pat0, steps);
         default: shown = (steps % 2 == 0) ? m_pat0 : 8'h00;
      endcase
      on = ((m_edges % 16) < m_duty) || (m_duty == 15);
      return on ? shown : 8'h00;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit acc;
      if (!rst_n) begin
         m_mode  = IDLE;
         m_pat0  = 8'h00;
         m_age   = 0;
         m_edges = 0;
         m_duty  = 15;
         m_ready = 1'b1;
         exp_q.delete();
      end else begin
         exp_q.push_back(model_leds());
         acc = cmd_valid && m_ready;
         if (acc && cmd_op == 2'd3) m_duty = int'(cmd_data[3:0]);
         if (acc && cmd_op != 2'd3) begin
            case (cmd_op)
               2'd0:    m_mode = STATIC;
               2'd1:    m_mode = ROTATE;
               default: m_mode = BLINK;
            endcase
            m_pat0 = cmd_data;
            m_age  = 0;
         end else begin
            m_age++;
         end
         m_ready = !acc;
         m_edges++;
      end
   end

   // ---------------- scoreboard: every cycle ----------------
   always @(negedge clk) begin
      logic [7:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      chk("leds", leds, e);
      chk("cmd_ready", cmd_ready, m_ready);
      chk("state", 32'(dbg_state), 32'(m_mode));
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [1:0] op, input logic [7:0] data);
      int n;
      n = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      while (!cmd_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready_seen", cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_leds", leds, 8'h00);
      chk("async_rst_state", 32'(dbg_state), 32'(IDLE));
      chk("async_rst_ready", cmd_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic count_value(input logic [7:0] v, output int cnt);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (leds == v) cnt++;
      end
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] s[0:32];
   int acc_cnt;
   int cnt;
   int n;

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // idle after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_leds", leds, 8'h00);
         chk("idle_ready", cmd_ready, 1'b1);
      end

      // static load
      send(OP_LOAD, 8'hA5);
      chk("ready_low_after_accept", cmd_ready, 1'b0);
      @(negedge clk);
      chk("ready_back_high", cmd_ready, 1'b1);
      chk("load_a5_first", leds, 8'hA5);
      repeat (50) @(negedge clk);
      chk("load_a5_hold", leds, 8'hA5);
      pulse_reset();

      // held valid: one accept every two cycles
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = OP_LOAD;
      cmd_data  = 8'h3C;
      acc_cnt   = 0;
      for (int i = 0; i < 8; i++) begin
         if (cmd_ready) acc_cnt++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk("held_valid_accepts", acc_cnt, 4);
      @(negedge clk);
      chk("load_3c", leds, 8'h3C);

      // rotate
      send(OP_ROTATE, 8'h81);
      for (int i = 0; i < 33; i++) begin
         @(negedge clk);
         s[i] = leds;
      end
      chk("rot_0", s[0], 8'h81);
      chk("rot_3", s[3], 8'h81);
      chk("rot_4", s[4], 8'h03);
      chk("rot_8", s[8], 8'h06);
      chk("rot_12", s[12], 8'h0C);
      chk("rot_wrap", s[32], 8'h81);

      // blink, then steady load during off phase
      send(OP_BLINK, 8'h0F);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         s[i] = leds;
      end
      chk("blink_on0", s[0], 8'h0F);
      chk("blink_on3", s[3], 8'h0F);
      chk("blink_off4", s[4], 8'h00);
      send(OP_LOAD, 8'h0F);
      chk("blink_off_at_accept", leds, 8'h00);
      @(negedge clk);
      chk("load_in_off_phase", leds, 8'h0F);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (leds == 8'h0F) cnt++;
      end
      chk("steady_after_blink", cnt, 8);

      // brightness
      send(OP_LOAD, 8'hFF);
      send(OP_BRIGHT, 8'h04);
      @(negedge clk);
      count_value(8'hFF, cnt);
      chk("bright4_on_count", cnt, 4);
      send(OP_BRIGHT, 8'h00);
      @(negedge clk);
      count_value(8'h00, cnt);
      chk("bright0_off_count", cnt, 16);
      send(OP_BRIGHT, 8'h0F);
      @(negedge clk);
      count_value(8'hFF, cnt);
      chk("bright15_on_count", cnt, 16);

      // rotate command landing on a step-pulse cycle
      send(OP_ROTATE, 8'h10);
      n = 0;
      while ((m_age % TD) != TD - 1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("step_sync_ready", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_op    = OP_ROTATE;
      cmd_data  = 8'h01;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         s[i] = leds;
      end
      chk("step_cmd_0", s[0], 8'h01);
      chk("step_cmd_3", s[3], 8'h01);
      chk("step_cmd_4", s[4], 8'h02);

      // reset mid-rotate restores full duty
      send(OP_BRIGHT, 8'h04);
      send(OP_ROTATE, 8'h81);
      repeat (6) @(negedge clk);
      pulse_reset();
      send(OP_LOAD, 8'hFF);
      @(negedge clk);
      count_value(8'hFF, cnt);
      chk("duty_full_after_reset", cnt, 16);

      // BRIGHT in IDLE keeps LEDs dark and state IDLE
      pulse_reset();
      send(OP_BRIGHT, 8'h04);
      chk("bright_idle_state", 32'(dbg_state), 32'(IDLE));
      count_value(8'h00, cnt);
      chk("bright_idle_dark", cnt, 16);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_op    = 2'($urandom_range(0, 3));
         cmd_data  = 8'($urandom);
         if (cmd_op == OP_BRIGHT && $urandom_range(0, 3) == 0)
            cmd_data = ($urandom_range(0, 1) == 1) ? 8'h0F : 8'h00;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (20) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

endmodule
